// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if
// Bundles every non-clock signal around the ALU arbiter: two request channels
// (valid/ready, operands, op), the registered ALU drive and its result/carry
// return, the tagged response channel, and the status outputs busy/ops_done.
// Modports:
//   slave  - the arbiter itself
//   master - the requesters, response consumer and ALU on the other side
interface alu_arbiter_if #(
  parameter int WIDTH = 16
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_op;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_op;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_op;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_carry;

  logic             busy;
  logic [15:0]      ops_done;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req0_ready, req1_ready,
    output alu_a, alu_b, alu_op,
    input  alu_result, alu_carry,
    output rsp_valid, rsp_id, rsp_result, rsp_carry,
    input  rsp_ready,
    output busy, ops_done
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req0_ready, req1_ready,
    input  alu_a, alu_b, alu_op,
    output alu_result, alu_carry,
    input  rsp_valid, rsp_id, rsp_result, rsp_carry,
    output rsp_ready,
    input  busy, ops_done
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares a single combinational ALU between two requesters. A round-robin
// grant picks one pending request in IDLE, its operands are registered onto
// the ALU for one EXEC cycle, and the captured result/carry is returned on a
// tagged response channel held stable until the consumer accepts it.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - alu_arbiter_if.slave (requests, ALU drive/return, response,
//           busy and the wrapping completed-operation counter ops_done)
module alu_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic             last_grant;
  logic             grant_any;
  logic             grant_id;
  logic             accept;
  logic             rsp_hs;

  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic             alu_op_q;
  logic             rsp_id_q;
  logic [WIDTH-1:0] rsp_result_q;
  logic             rsp_carry_q;
  logic [15:0]      ops_done_q;

  // Round-robin choice: a lone requester always wins; on a tie the one that
  // was not served last goes first.
  always_comb begin
    grant_any = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_id = ~last_grant;
    end else begin
      grant_id = bus.req1_valid;
    end
  end

  // Ready is gated by rst_n so nothing looks accepted while reset is held.
  assign accept         = rst_n && (state == IDLE) && grant_any;
  assign rsp_hs         = (state == RESP) && bus.rsp_ready;
  assign bus.req0_ready = accept && !grant_id;
  assign bus.req1_ready = accept && grant_id;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_any) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand capture on grant, result capture at the end of EXEC, and the
  // bookkeeping (counter, round-robin pointer) on the response handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      ops_done_q   <= 16'd0;
      last_grant   <= 1'b1;
    end else begin
      if (state == IDLE && grant_any) begin
        alu_a_q  <= grant_id ? bus.req1_a  : bus.req0_a;
        alu_b_q  <= grant_id ? bus.req1_b  : bus.req0_b;
        alu_op_q <= grant_id ? bus.req1_op : bus.req0_op;
        rsp_id_q <= grant_id;
      end
      if (state == EXEC) begin
        rsp_result_q <= bus.alu_result;
        rsp_carry_q  <= bus.alu_carry;
      end
      if (rsp_hs) begin
        ops_done_q <= ops_done_q + 16'd1;
        last_grant <= rsp_id_q;
      end
    end
  end

  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_carry  = rsp_carry_q;
  assign bus.busy       = (state != IDLE);
  assign bus.ops_done   = ops_done_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
// Scoreboard bench for alu_arbiter. A driver process feeds per-requester
// pending queues onto the request ports and, when a request is accepted,
// pushes the expected response computed from its operands. Scenario tasks
// pop the scoreboard when a response appears and compare it inline.
module tb_alu_arbiter;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        op;
  } req_t;

  typedef struct packed {
    logic        id;
    logic [15:0] result;
    logic        carry;
    int          acc_cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   cyc;
  int   exp_ops;

  req_t pend0[$];
  req_t pend1[$];
  exp_t sb[$];

  alu_arbiter_if #(.WIDTH(16)) bus();

  alu_arbiter #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ALU sitting on the far side of the arbiter
  always_comb begin
    if (bus.alu_op) begin
      {bus.alu_carry, bus.alu_result} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
    end else begin
      {bus.alu_carry, bus.alu_result} = {1'b0, bus.alu_a & bus.alu_b};
    end
  end

  function automatic exp_t model(input logic id, input req_t r, input int c);
    exp_t e;
    logic [16:0] s;
    e.id = id;
    e.acc_cyc = c;
    if (r.op) begin
      s = {1'b0, r.a} + {1'b0, r.b};
      e.result = s[15:0];
      e.carry = s[16];
    end else begin
      e.result = r.a & r.b;
      e.carry = 1'b0;
    end
    return e;
  endfunction

  // Request driver: acceptance is sampled at the falling edge, booked into
  // the scoreboard just after the rising edge, then the next request is driven.
  initial begin
    logic acc0;
    logic acc1;
    cyc = 0;
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = 1'b0;
    forever begin
      @(negedge clk);
      acc0 = bus.req0_valid && bus.req0_ready;
      acc1 = bus.req1_valid && bus.req1_ready;
      @(posedge clk);
      cyc++;
      #1;
      if (acc0 && rst_n && pend0.size() > 0) begin
        sb.push_back(model(1'b0, pend0[0], cyc));
        void'(pend0.pop_front());
      end
      if (acc1 && rst_n && pend1.size() > 0) begin
        sb.push_back(model(1'b1, pend1[0], cyc));
        void'(pend1.pop_front());
      end
      bus.req0_valid = (pend0.size() > 0);
      bus.req1_valid = (pend1.size() > 0);
      if (pend0.size() > 0) begin
        bus.req0_a = pend0[0].a; bus.req0_b = pend0[0].b; bus.req0_op = pend0[0].op;
      end
      if (pend1.size() > 0) begin
        bus.req1_a = pend1[0].a; bus.req1_b = pend1[0].b; bus.req1_op = pend1[0].op;
      end
    end
  end

  // Waits a bounded number of cycles for rsp_valid and pops the matching
  // expected entry; ok=0 means no response or nothing was expected.
  task automatic get_rsp(input int budget, output bit ok, output exp_t e);
    ok = 1'b0;
    e = '0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #3;
      if (bus.rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok && sb.size() > 0) e = sb.pop_front();
    else ok = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%0b exp=0", bus.busy); end
    checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rsp_valid got=%0b exp=0", bus.rsp_valid); end
    checks++; if (bus.rsp_id !== 1'b0) begin failures++; $display("[TB] FAIL reset_rsp_id got=%0b exp=0", bus.rsp_id); end
    checks++; if (bus.rsp_result !== 16'h0000) begin failures++; $display("[TB] FAIL reset_rsp_result got=%0h exp=0", bus.rsp_result); end
    checks++; if (bus.rsp_carry !== 1'b0) begin failures++; $display("[TB] FAIL reset_rsp_carry got=%0b exp=0", bus.rsp_carry); end
    checks++; if ({bus.alu_a, bus.alu_b, bus.alu_op} !== 33'd0) begin failures++; $display("[TB] FAIL reset_alu got=%0h/%0h/%0b exp=0/0/0", bus.alu_a, bus.alu_b, bus.alu_op); end
    checks++; if (bus.ops_done !== 16'd0) begin failures++; $display("[TB] FAIL reset_ops_done got=%0d exp=0", bus.ops_done); end
    checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin failures++; $display("[TB] FAIL reset_ready got=%b exp=00", {bus.req0_ready, bus.req1_ready}); end
    rst_n = 1'b1;
    exp_ops = 0;
  endtask

  task automatic test_add_carry();
    bit ok;
    exp_t e;
    pend0.push_back('{a: 16'hFFFF, b: 16'h0001, op: 1'b1});
    get_rsp(12, ok, e);
    checks++;
    if (!ok) begin
      failures++; $display("[TB] FAIL add_rsp got=none exp=response");
    end else begin
      if ({bus.rsp_id, bus.rsp_result, bus.rsp_carry} !== {e.id, e.result, e.carry}) begin
        failures++; $display("[TB] FAIL add_rsp got=id%0d %0h c%0b exp=id%0d %0h c%0b", bus.rsp_id, bus.rsp_result, bus.rsp_carry, e.id, e.result, e.carry);
      end
      checks++;
      if (cyc - e.acc_cyc !== 1) begin failures++; $display("[TB] FAIL add_latency got=%0d exp=1", cyc - e.acc_cyc); end
      exp_ops++;
    end
    @(posedge clk); #3;
    checks++; if (bus.ops_done !== exp_ops[15:0]) begin failures++; $display("[TB] FAIL add_ops_done got=%0d exp=%0d", bus.ops_done, exp_ops); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL add_busy_after got=%0b exp=0", bus.busy); end
  endtask

  task automatic test_and_op();
    bit ok;
    exp_t e;
    pend1.push_back('{a: 16'hF0F0, b: 16'h0FF0, op: 1'b0});
    get_rsp(12, ok, e);
    checks++;
    if (!ok) begin
      failures++; $display("[TB] FAIL and_rsp got=none exp=response");
    end else begin
      if ({bus.rsp_id, bus.rsp_result, bus.rsp_carry} !== {1'b1, 16'h00F0, 1'b0} || e.result !== 16'h00F0) begin
        failures++; $display("[TB] FAIL and_rsp got=id%0d %0h c%0b exp=id1 00f0 c0", bus.rsp_id, bus.rsp_result, bus.rsp_carry);
      end
      exp_ops++;
    end
  endtask

  task automatic test_both_from_reset();
    bit ok;
    exp_t e;
    @(posedge clk); #3;
    rst_n = 1'b0;
    sb.delete();
    exp_ops = 0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    pend0.push_back('{a: 16'h1234, b: 16'h0001, op: 1'b1});
    pend1.push_back('{a: 16'h0002, b: 16'h0003, op: 1'b1});
    @(posedge clk); #3;
    checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin failures++; $display("[TB] FAIL both_first_grant got=%b exp=10", {bus.req0_ready, bus.req1_ready}); end
    for (int i = 0; i < 2; i++) begin
      get_rsp(12, ok, e);
      checks++;
      if (!ok) begin
        failures++; $display("[TB] FAIL both_rsp%0d got=none exp=response", i);
      end else begin
        if ({bus.rsp_id, bus.rsp_result, bus.rsp_carry} !== {e.id, e.result, e.carry} || bus.rsp_id !== i[0]) begin
          failures++; $display("[TB] FAIL both_rsp%0d got=id%0d %0h exp=id%0d %0h", i, bus.rsp_id, bus.rsp_result, i, e.result);
        end
        exp_ops++;
      end
    end
    @(posedge clk); #3;
    checks++; if (bus.ops_done !== 16'd2) begin failures++; $display("[TB] FAIL both_ops_done got=%0d exp=2", bus.ops_done); end
  endtask

  task automatic test_round_robin();
    bit ok;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      pend0.push_back('{a: 16'($urandom), b: 16'($urandom), op: 1'($urandom)});
      pend1.push_back('{a: 16'($urandom), b: 16'($urandom), op: 1'($urandom)});
    end
    for (int i = 0; i < 6; i++) begin
      get_rsp(12, ok, e);
      checks++;
      if (!ok) begin
        failures++; $display("[TB] FAIL rr_rsp%0d got=none exp=response", i);
      end else begin
        if (bus.rsp_id !== i[0] || {bus.rsp_id, bus.rsp_result, bus.rsp_carry} !== {e.id, e.result, e.carry}) begin
          failures++; $display("[TB] FAIL rr_rsp%0d got=id%0d %0h c%0b exp=id%0d %0h c%0b", i, bus.rsp_id, bus.rsp_result, bus.rsp_carry, i[0], e.result, e.carry);
        end
        exp_ops++;
      end
    end
    @(posedge clk); #3;
    checks++; if (bus.ops_done !== exp_ops[15:0]) begin failures++; $display("[TB] FAIL rr_ops_done got=%0d exp=%0d", bus.ops_done, exp_ops); end
  endtask

  task automatic test_backpressure();
    bit ok;
    exp_t e;
    bus.rsp_ready = 1'b0;
    pend0.push_back('{a: 16'h8001, b: 16'h8002, op: 1'b1});
    pend1.push_back('{a: 16'hAAAA, b: 16'h5555, op: 1'b1});
    get_rsp(12, ok, e);
    checks++;
    if (!ok) begin
      failures++; $display("[TB] FAIL bp_rsp got=none exp=response");
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #3;
      checks++;
      if (bus.rsp_valid !== 1'b1 || {bus.rsp_id, bus.rsp_result, bus.rsp_carry} !== {1'b0, 16'h0003, 1'b1} || bus.busy !== 1'b1) begin
        failures++; $display("[TB] FAIL bp_hold%0d got=v%0b id%0d %0h c%0b busy%0b exp=v1 id0 0003 c1 busy1", i, bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_carry, bus.busy);
      end
      checks++;
      if ({bus.req0_ready, bus.req1_ready} !== 2'b00 || bus.ops_done !== exp_ops[15:0]) begin
        failures++; $display("[TB] FAIL bp_stall%0d got=rdy%b ops%0d exp=rdy00 ops%0d", i, {bus.req0_ready, bus.req1_ready}, bus.ops_done, exp_ops);
      end
    end
    bus.rsp_ready = 1'b1;
    if (ok) exp_ops++;
    @(posedge clk); #3;
    checks++; if (bus.ops_done !== exp_ops[15:0] || bus.rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL bp_release got=ops%0d v%0b exp=ops%0d v0", bus.ops_done, bus.rsp_valid, exp_ops); end
    get_rsp(12, ok, e);
    checks++;
    if (!ok || {bus.rsp_id, bus.rsp_result, bus.rsp_carry} !== {e.id, e.result, e.carry} || bus.rsp_id !== 1'b1) begin
      failures++; $display("[TB] FAIL bp_second got=ok%0b id%0d %0h exp=id1 %0h", ok, bus.rsp_id, bus.rsp_result, e.result);
    end
    if (ok) exp_ops++;
  endtask

  task automatic test_reset_mid_exec();
    bit ok;
    bit seen;
    exp_t e;
    pend0.push_back('{a: 16'h0F0F, b: 16'h00FF, op: 1'b0});
    get_rsp(12, ok, e);
    checks++;
    if (!ok || {bus.rsp_id, bus.rsp_result} !== {1'b0, 16'h000F}) begin failures++; $display("[TB] FAIL rst_pre got=ok%0b id%0d %0h exp=id0 000f", ok, bus.rsp_id, bus.rsp_result); end
    @(posedge clk); #3;
    pend1.push_back('{a: 16'h7777, b: 16'h1111, op: 1'b1});
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #3;
      if (bus.busy) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin failures++; $display("[TB] FAIL rst_exec_entry got=idle exp=busy"); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.rsp_valid, bus.rsp_id, bus.rsp_carry, bus.alu_op} !== 5'b0 || {bus.alu_a, bus.alu_b, bus.rsp_result, bus.ops_done} !== 64'd0) begin
      failures++; $display("[TB] FAIL rst_async got=busy%0b v%0b alu_a%0h ops%0d exp=all zero", bus.busy, bus.rsp_valid, bus.alu_a, bus.ops_done);
    end
    sb.delete();
    exp_ops = 0;
    @(posedge clk);
    @(posedge clk); #3;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #3;
      if (bus.rsp_valid || bus.busy) seen = 1'b1;
    end
    checks++;
    if (seen) begin failures++; $display("[TB] FAIL rst_dropped got=activity exp=idle"); end
    pend0.push_back('{a: 16'h0100, b: 16'h0200, op: 1'b1});
    pend1.push_back('{a: 16'hFFFF, b: 16'hFFFF, op: 1'b1});
    for (int i = 0; i < 2; i++) begin
      get_rsp(12, ok, e);
      checks++;
      if (!ok || bus.rsp_id !== i[0] || {bus.rsp_result, bus.rsp_carry} !== {e.result, e.carry}) begin
        failures++; $display("[TB] FAIL rst_after%0d got=ok%0b id%0d %0h c%0b exp=id%0d %0h c%0b", i, ok, bus.rsp_id, bus.rsp_result, bus.rsp_carry, i[0], e.result, e.carry);
      end
      if (ok) exp_ops++;
    end
    @(posedge clk); #3;
    checks++; if (bus.ops_done !== 16'd2) begin failures++; $display("[TB] FAIL rst_ops_done got=%0d exp=2", bus.ops_done); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    exp_ops = 0;
    rst_n = 1'b0;
    bus.rsp_ready = 1'b1;
    test_reset();
    test_add_carry();
    test_and_op();
    test_both_from_reset();
    test_round_robin();
    test_backpressure();
    test_reset_mid_exec();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Sequencing controller that shares one 16-bit ALU (ADD when op=1 with carry-in 0, AND when op=0 with carry forced 0) between two requesters. Each requester issues operands and an op code through a valid/ready handshake. The block round-robin arbitrates, drives registered operands to the ALU, captures the result and carry, and returns them on a single tagged response channel. It sits between the control unit / datapath clients and the ALU instance.

## Interface
- WIDTH, 16, operand/result width; must equal ALU width
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  one clock; reset is asynchronous and active-low
- req0_valid / req1_valid  in  1  requester n has an operation pending
- req0_ready / req1_ready  out  1  request n accepted this cycle
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands
- req0_op / req1_op  in  1  1 = ADD, 0 = AND
- alu_a, alu_b  out  WIDTH  registered operands to ALU
- alu_op  out  1  registered op to ALU
- alu_result  in  WIDTH  ALU result (combinational from alu_a/alu_b/alu_op)
- alu_carry  in  1  ALU carry out
- rsp_valid  out  1  response pending
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester that owns the response
- rsp_result  out  WIDTH  captured result
- rsp_carry  out  1  captured carry (always 0 for AND)
- busy  out  1  state != IDLE
- ops_done  out  16  completed-response counter, wraps 0xFFFF -> 0x0000

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: if any req_valid, grant one requester; assert its req_ready combinationally this cycle (ready = IDLE && grant). On the same edge, capture a/b/op into alu_a/alu_b/alu_op, set rsp_id, and go to EXEC. With no request, stay in IDLE.
- EXEC: ALU evaluates the registered operands. At the end of the cycle, latch alu_result/alu_carry into rsp_result/rsp_carry and go to RESP.
- RESP: rsp_valid=1. rsp_result, rsp_carry and rsp_id are held stable until rsp_ready=1. On handshake: ops_done += 1, priority pointer updates, go to IDLE.
- Arbitration: round-robin with a last_grant register, reset value 1, so requester 0 wins the first tie. Single requester valid: it wins regardless of pointer. Both valid: the requester not equal to last_grant wins. last_grant <= rsp_id on response handshake.
- Ungranted requester sees ready=0 and must hold its request; no ready outside IDLE.
- Arithmetic: ADD result = (a+b) mod 2^WIDTH, carry = bit WIDTH of the sum. AND result = a&b, carry = 0. The block passes ALU outputs through unmodified.

## Timing
- Reset values: state IDLE; req0_ready=req1_ready=0 (no request visible); alu_a=alu_b=0; alu_op=0; rsp_valid=0; rsp_id=0; rsp_result=0; rsp_carry=0; busy=0; ops_done=0; last_grant=1.
- Latency: accept at cycle T, EXEC at T+1, rsp_valid high from T+2. Best throughput is one op per 3 cycles (rsp_ready high at T+2 gives IDLE at T+3).
- No new request is accepted in the cycle rsp handshakes. Acceptance resumes the following IDLE cycle.
- busy rises the cycle after acceptance and falls the cycle after response handshake.
- Reset asserted mid-EXEC or mid-RESP: immediately return to IDLE and reset values. The in-flight operation is dropped, with no response and no ops_done increment.
- rsp_ready while not in RESP is ignored.

## Test plan
- Req0 ADD a=0xFFFF b=0x0001 -> req0_ready at T; rsp at T+2: rsp_id=0, rsp_result=0x0000, rsp_carry=1, ops_done=1.
- Req1 AND a=0xF0F0 b=0x0FF0 -> rsp_id=1, rsp_result=0x00F0, rsp_carry=0.
- Both valid from reset with req0 ADD 0x1234+0x0001 and req1 ADD 0x0002+0x0003, rsp_ready=1 -> responses in order id0 0x1235, then id1 0x0005; req1_ready=0 during first transaction; ops_done=2.
- Both valid continuously for 6 ops -> grants alternate 0,1,0,1,0,1.
- rsp_ready held 0 for 5 cycles in RESP -> rsp_valid, rsp_result, rsp_carry, rsp_id stable; req ready=0; busy=1; single ops_done increment on release.
- rst_n pulsed low during EXEC -> all outputs at reset values asynchronously; no response emitted; next request after release handled normally with requester 0 priority.
